// File: rtl/isa_pkg.sv
// isa_pkg: instruction field layout, NOP word, RS2-use rule and issue FSM states.
package isa_pkg;
  localparam int INSTR_W = 32;
  localparam int REG_W   = 5;
  localparam int OP_LSB  = 26;
  localparam int WS1_LSB = 21;
  localparam int RS1_LSB = 16;
  localparam int RS2_LSB = 11;
  localparam int IMM_BIT = 29;
  localparam logic [INSTR_W-1:0] NOP = '0;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  // Immediate forms and the unary MOV/NOT ops leave the RS2 field unused.
  function automatic logic uses_rs2(input logic [INSTR_W-1:0] w);
    return !w[IMM_BIT] && w[OP_LSB+:3] > 3'd1;
  endfunction
endpackage

// File: rtl/instr_store.sv
// instr_store: instruction array with one write port and one asynchronous read port; not reset.
module instr_store
  import isa_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);
  logic [INSTR_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_issue.sv
// instr_issue: issues a loaded program to the pipeline, then drains with NOPs and pulses done.
// Define INSTR_ISSUE_HAZARD_EN to add RAW-hazard bubbles against the last HAZ_WINDOW issued dests.
module instr_issue
  import isa_pkg::*;
#(
  parameter int IMEM_DEPTH   = 32,
  parameter int DRAIN_CYCLES = 4,
  parameter int HAZ_WINDOW   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
  input  logic [31:0]                   load_data,
  input  logic [$clog2(IMEM_DEPTH):0]   prog_len,
  input  logic                          start,
  input  logic                          hold,
  output logic [31:0]                   InstrOut,
  output logic                          instr_valid,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc,
  output logic                          busy,
  output logic                          done
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  state_t state, nxt;
  logic [AW:0] len, len_in;
  logic [DW-1:0] dcnt;
  logic [31:0] word;
  logic stall, issue, last, dend;
  instr_store #(.DEPTH(IMEM_DEPTH)) u_store (
    .clk(clk), .we(load_en && state == IDLE), .waddr(load_addr), .wdata(load_data),
    .raddr(pc), .rdata(word)
  );
  assign len_in = prog_len > (AW+1)'(IMEM_DEPTH) ? (AW+1)'(IMEM_DEPTH) : prog_len;
  assign last   = {1'b0, pc} == len - (AW+1)'(1);
  assign dend   = dcnt == DW'(DRAIN_CYCLES - 1);
  assign issue  = state == RUN && !stall;
  assign busy   = state != IDLE;
  assign done   = state == DONE;
`ifdef INSTR_ISSUE_HAZARD_EN
  logic [HAZ_WINDOW-1:0][REG_W-1:0] hdst;
  logic [HAZ_WINDOW-1:0] hval;
  logic haz;
  always_comb begin
    haz = 1'b0;
    for (int i = 0; i < HAZ_WINDOW; i++)
      haz = haz | (hval[i] && (hdst[i] == word[RS1_LSB+:REG_W] ||
                               (uses_rs2(word) && hdst[i] == word[RS2_LSB+:REG_W])));
  end
  // Bubbles shift in invalid entries so a stalled consumer eventually clears the window.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hval <= '0;
      hdst <= '0;
    end else if (state == IDLE && start) begin
      hval <= '0;
    end else if (state == RUN) begin
      hval[0] <= issue;
      hdst[0] <= word[WS1_LSB+:REG_W];
      for (int i = 1; i < HAZ_WINDOW; i++) begin
        hval[i] <= hval[i-1];
        hdst[i] <= hdst[i-1];
      end
    end
  assign stall = hold | haz;
`else
  assign stall = hold;
`endif
  always_comb begin
    nxt = state == IDLE  ? (start ? (len_in == '0 ? DRAIN : RUN) : IDLE) :
          state == RUN   ? (issue && last ? DRAIN : RUN) :
          state == DRAIN ? (dend ? DONE : DRAIN) : IDLE;
  end
  // pc stops on the last instruction rather than stepping past the program end.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      len         <= '0;
      dcnt        <= '0;
      InstrOut    <= NOP;
      instr_valid <= 1'b0;
    end else begin
      state       <= nxt;
      InstrOut    <= issue ? word : NOP;
      instr_valid <= issue;
      dcnt        <= state == DRAIN ? dcnt + DW'(1) : '0;
      if (state == IDLE && start) begin
        pc  <= '0;
        len <= len_in;
      end else if (issue && !last) begin
        pc <= pc + AW'(1);
      end
    end
endmodule

// File: tb/tb_instr_issue.sv
// tb_instr_issue: directed programs with a scoreboard of per-cycle expected outputs while busy.
module tb_instr_issue;
  localparam int AW = 5;
  typedef struct packed {
    logic [31:0]   ins;
    logic          v;
    logic          d;
    logic          cp;
    logic [AW-1:0] pc;
  } exp_t;
  logic clk = 0, rst = 1, load_en = 0, start = 0, hold = 0;
  logic [AW-1:0] load_addr = '0;
  logic [31:0] load_data = '0;
  logic [AW:0] prog_len = '0;
  logic [31:0] InstrOut;
  logic instr_valid, busy, done;
  logic [AW-1:0] pc;
  exp_t sbq[$];
  int checks = 0, errors = 0;
  string tname = "reset";
  logic [31:0] w0, w1, w2, addi, subi, add9, mov9, addr11;

  always #5 clk = ~clk;

  instr_issue dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .prog_len(prog_len), .start(start), .hold(hold), .InstrOut(InstrOut),
    .instr_valid(instr_valid), .pc(pc), .busy(busy), .done(done)
  );

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] d, s1, s2,
                                      input logic [10:0] imm);
    return {op, d, s1, s2, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] ins, input logic v, input logic d, input logic cp,
                      input logic [AW-1:0] p);
    exp_t e;
    e.ins = ins; e.v = v; e.d = d; e.cp = cp; e.pc = p;
    sbq.push_back(e);
  endtask

  task automatic push_tail(input logic [31:0] lw);
    push(lw, 1, 0, 0, 0);
    repeat (3) push(0, 0, 0, 0, 0);
    push(0, 0, 1, 0, 0);
  endtask

  task automatic load(input int a, input logic [31:0] d);
    load_en = 1; load_addr = AW'(a); load_data = d;
    tick();
    load_en = 0;
  endtask

  task automatic start_prog(input int n);
    prog_len = (AW+1)'(n); start = 1;
    tick();
    start = 0;
  endtask

  task automatic finish_test();
    int n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    chk({tname, "_terminates"}, {31'd0, busy}, 0);
    chk({tname, "_all_outputs_seen"}, sbq.size(), 0);
    chk({tname, "_idle_instr"}, InstrOut, 0);
    chk({tname, "_idle_valid"}, {31'd0, instr_valid}, 0);
    sbq.delete();
  endtask

  task automatic push_basic();
    push(0, 0, 0, 1, 0);
    push(w0, 1, 0, 1, 1);
    push(w1, 1, 0, 1, 2);
    push_tail(w2);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && busy) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL %s extra_output: ins=%h v=%b done=%b", tname, InstrOut, instr_valid, done);
      end else begin
        e = sbq.pop_front();
        if (InstrOut !== e.ins || instr_valid !== e.v || done !== e.d || (e.cp && pc !== e.pc)) begin
          errors++;
          $display("FAIL %s cycle: got ins=%h v=%b done=%b pc=%0d, expected ins=%h v=%b done=%b pc=%0d(chk=%b)",
                   tname, InstrOut, instr_valid, done, pc, e.ins, e.v, e.d, e.pc, e.cp);
        end
      end
    end else if (!rst && (done || instr_valid)) begin
      checks++;
      errors++;
      $display("FAIL %s idle_output: got done=%b v=%b expected 0 0", tname, done, instr_valid);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    w0     = enc(6'd0, 5'd2, 5'd1, 5'd0, 11'd0);
    w1     = enc(6'd1, 5'd3, 5'd4, 5'd0, 11'd0);
    w2     = enc(6'd2, 5'd11, 5'd10, 5'd5, 11'd0);
    addi   = enc(6'b001010, 5'd11, 5'd6, 5'd0, 11'd413);
    subi   = enc(6'b001011, 5'd12, 5'd11, 5'd0, 11'd413);
    add9   = enc(6'd2, 5'd9, 5'd7, 5'd8, 11'd0);
    mov9   = enc(6'd0, 5'd9, 5'd7, 5'd11, 11'd0);
    addr11 = enc(6'd2, 5'd9, 5'd7, 5'd11, 11'd0);
    repeat (2) tick();
    chk("rst_instr", InstrOut, 0);
    chk("rst_valid", {31'd0, instr_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_pc", {27'd0, pc}, 0);
    rst = 0;
    tick();
    load(0, w0); load(1, w1); load(2, w2);
    tname = "basic";
    push_basic();
    start_prog(3);
    finish_test();
    // hold two cycles after first issue; load/start while running must be ignored
    tname = "hold";
    push(0, 0, 0, 1, 0);
    push(w0, 1, 0, 1, 1);
    push(0, 0, 0, 1, 1);
    push(0, 0, 0, 1, 1);
    push(w1, 1, 0, 1, 2);
    push_tail(w2);
    prog_len = 3; start = 1;
    tick();
    load_en = 1; load_addr = 2; load_data = 32'hDEADBEEF; prog_len = 1;
    tick();
    load_en = 0; start = 0; hold = 1;
    tick(); tick();
    hold = 0;
    tick(); tick();
    hold = 1;
    finish_test();
    hold = 0;
    load(0, addi); load(1, subi);
    tname = "haz_rs1";
    push(0, 0, 0, 1, 0);
    push(addi, 1, 0, 1, 1);
`ifdef INSTR_ISSUE_HAZARD_EN
    push(0, 0, 0, 1, 1);
    push(0, 0, 0, 1, 1);
`endif
    push_tail(subi);
    start_prog(2);
    finish_test();
    load(1, add9); load(2, mov9);
    tname = "haz_none";
    push(0, 0, 0, 1, 0);
    push(addi, 1, 0, 1, 1);
    push(add9, 1, 0, 1, 2);
    push_tail(mov9);
    start_prog(3);
    finish_test();
    load(1, addr11);
    tname = "haz_rs2";
    push(0, 0, 0, 1, 0);
    push(addi, 1, 0, 1, 1);
`ifdef INSTR_ISSUE_HAZARD_EN
    push(0, 0, 0, 1, 1);
    push(0, 0, 0, 1, 1);
`endif
    push_tail(addr11);
    start_prog(2);
    finish_test();
    tname = "len0";
    push(0, 0, 0, 1, 0);
    repeat (3) push(0, 0, 0, 0, 0);
    push(0, 0, 1, 0, 0);
    start_prog(0);
    finish_test();
    // reset while running at pc=2, then rerun from a store that must be intact
    load(0, w0); load(1, w1); load(2, w2);
    tname = "rst_mid";
    push(0, 0, 0, 1, 0);
    push(w0, 1, 0, 1, 1);
    push(w1, 1, 0, 1, 2);
    start_prog(3);
    tick(); tick();
    @(negedge clk);
    #1;
    chk("rst_mid_pc_before", {27'd0, pc}, 2);
    rst = 1;
    #1;
    chk("rst_mid_instr", InstrOut, 0);
    chk("rst_mid_busy", {31'd0, busy}, 0);
    chk("rst_mid_valid", {31'd0, instr_valid}, 0);
    chk("rst_mid_pc", {27'd0, pc}, 0);
    chk("rst_mid_sb_empty", sbq.size(), 0);
    tick();
    chk("rst_mid_edge_instr", InstrOut, 0);
    chk("rst_mid_edge_busy", {31'd0, busy}, 0);
    rst = 0;
    tick();
    tname = "rerun";
    push_basic();
    start_prog(3);
    finish_test();
    // full store, prog_len above depth saturates to 32
    for (int i = 0; i < 32; i++) load(i, enc(6'b001000, 5'd1, 5'd0, 5'd0, 11'(i + 1)));
    tname = "sat";
    push(0, 0, 0, 1, 0);
    for (int k = 0; k < 31; k++) push(enc(6'b001000, 5'd1, 5'd0, 5'd0, 11'(k + 1)), 1, 0, 1, AW'(k + 1));
    push_tail(enc(6'b001000, 5'd1, 5'd0, 5'd0, 11'd32));
    start_prog(40);
    finish_test();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
